// File: rtl/reorder_buffer_param.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_param
// Purpose  : Parametrised in-order-retire reorder buffer with CDB capture,
//            operand forwarding and commit-time mispredict flush.
//            Optional perf counters when ROB_PERF_CNT_EN is defined.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module reorder_buffer_param #(
    parameter int ROB_WIDTH = 3,
    parameter int XLEN      = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    output logic [ROB_WIDTH-1:0] issue_tag,
    input  logic [6:0]           issue_type,
    input  logic [4:0]           issue_rd,
    input  logic [XLEN-1:0]      issue_pc,
    input  logic [XLEN-1:0]      issue_pred_pc,
    input  logic                 issue_done,
    input  logic [XLEN-1:0]      issue_value,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [XLEN-1:0]      cdb_value,
    input  logic [XLEN-1:0]      cdb_next_pc,
    input  logic [ROB_WIDTH-1:0] qry1_tag,
    input  logic [ROB_WIDTH-1:0] qry2_tag,
    output logic                 qry1_ready,
    output logic                 qry2_ready,
    output logic [XLEN-1:0]      qry1_value,
    output logic [XLEN-1:0]      qry2_value,
    output logic                 commit_valid,
    output logic [ROB_WIDTH-1:0] commit_tag,
    output logic [4:0]           commit_rd,
    output logic [XLEN-1:0]      commit_value,
    output logic                 commit_store,
    output logic                 flush_out,
    output logic [XLEN-1:0]      flush_pc
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_commit_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    localparam int ROB_SIZE = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] c_full_count = (ROB_WIDTH+1)'(ROB_SIZE);
    localparam logic [6:0] c_t_jal  = 7'd3;
    localparam logic [6:0] c_t_beq  = 7'd5;
    localparam logic [6:0] c_t_bgeu = 7'd10;
    localparam logic [6:0] c_t_sb   = 7'd16;
    localparam logic [6:0] c_t_sw   = 7'd18;

    logic [ROB_SIZE-1:0]  r_busy;
    logic [ROB_SIZE-1:0]  r_done;
    logic [6:0]           r_type    [ROB_SIZE];
    logic [4:0]           r_rd      [ROB_SIZE];
    logic [XLEN-1:0]      r_pred_pc [ROB_SIZE];
    logic [XLEN-1:0]      r_value   [ROB_SIZE];
    logic [XLEN-1:0]      r_next_pc [ROB_SIZE];
    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;

    logic w_issue_fire, w_cdb_fire, w_commit, w_flush;
    logic w_head_ctl, w_head_branch, w_head_store;
    logic w_q1_hit, w_q2_hit;

    // Full buffer blocks issue even when the head retires this cycle.
    assign issue_ready = (r_count < c_full_count);
    assign issue_tag   = r_tail;

    assign w_issue_fire  = rdy_in && issue_valid && issue_ready;
    assign w_cdb_fire    = rdy_in && cdb_valid && r_busy[cdb_tag];
    assign w_commit      = rdy_in && r_busy[r_head] && r_done[r_head];
    assign w_head_ctl    = (r_type[r_head] >= c_t_jal) && (r_type[r_head] <= c_t_bgeu);
    assign w_head_branch = (r_type[r_head] >= c_t_beq) && (r_type[r_head] <= c_t_bgeu);
    assign w_head_store  = (r_type[r_head] >= c_t_sb)  && (r_type[r_head] <= c_t_sw);
    assign w_flush       = w_commit && w_head_ctl && (r_next_pc[r_head] != r_pred_pc[r_head]);

    assign w_q1_hit   = cdb_valid && (cdb_tag == qry1_tag) && r_busy[qry1_tag];
    assign w_q2_hit   = cdb_valid && (cdb_tag == qry2_tag) && r_busy[qry2_tag];
    assign qry1_ready = w_q1_hit || (r_busy[qry1_tag] && r_done[qry1_tag]);
    assign qry2_ready = w_q2_hit || (r_busy[qry2_tag] && r_done[qry2_tag]);
    assign qry1_value = w_q1_hit ? cdb_value : r_value[qry1_tag];
    assign qry2_value = w_q2_hit ? cdb_value : r_value[qry2_tag];

    // Payload storage; validity is tracked solely by r_busy, so no reset needed.
    // Non-control entries default next_pc to the fall-through address.
    always_ff @(posedge clk_in) begin
        if (w_issue_fire && !w_flush) begin
            r_type[r_tail]    <= issue_type;
            r_rd[r_tail]      <= issue_rd;
            r_pred_pc[r_tail] <= issue_pred_pc;
            r_done[r_tail]    <= issue_done;
            r_value[r_tail]   <= issue_value;
            r_next_pc[r_tail] <= issue_pc + XLEN'(4);
        end
        if (w_cdb_fire && !w_flush) begin
            r_done[cdb_tag]    <= 1'b1;
            r_value[cdb_tag]   <= cdb_value;
            r_next_pc[cdb_tag] <= cdb_next_pc;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy       <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_store <= 1'b0;
            flush_out    <= 1'b0;
            flush_pc     <= '0;
`ifdef ROB_PERF_CNT_EN
            perf_commit_cnt <= '0;
            perf_flush_cnt  <= '0;
`endif
        end else begin
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            flush_out    <= 1'b0;
            if (w_commit) begin
                commit_valid <= 1'b1;
                commit_tag   <= r_head;
                commit_rd    <= (w_head_branch || w_head_store) ? 5'd0 : r_rd[r_head];
                commit_value <= r_value[r_head];
                commit_store <= w_head_store;
`ifdef ROB_PERF_CNT_EN
                perf_commit_cnt <= perf_commit_cnt + 32'd1;
`endif
            end
            if (w_flush) begin
                flush_out <= 1'b1;
                flush_pc  <= r_next_pc[r_head];
                r_busy    <= '0;
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
`ifdef ROB_PERF_CNT_EN
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
`endif
            end else begin
                if (w_issue_fire) begin
                    r_busy[r_tail] <= 1'b1;
                    r_tail         <= r_tail + 1'b1;
                end
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                end
                if (w_issue_fire && !w_commit)
                    r_count <= r_count + 1'b1;
                else if (!w_issue_fire && w_commit)
                    r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer_param
// Purpose  : Scoreboard bench for reorder_buffer_param (ROB_WIDTH=3, XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer_param;

    localparam int RW = 3;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rdy_in = 1'b1;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [RW-1:0] issue_tag;
    logic [6:0]    issue_type = '0;
    logic [4:0]    issue_rd = '0;
    logic [31:0]   issue_pc = '0, issue_pred_pc = '0, issue_value = '0;
    logic          issue_done = 1'b0;
    logic          cdb_valid = 1'b0;
    logic [RW-1:0] cdb_tag = '0;
    logic [31:0]   cdb_value = '0, cdb_next_pc = '0;
    logic [RW-1:0] qry1_tag = '0, qry2_tag = '0;
    logic          qry1_ready, qry2_ready;
    logic [31:0]   qry1_value, qry2_value;
    logic          commit_valid, commit_store, flush_out;
    logic [RW-1:0] commit_tag;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_value, flush_pc;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]   perf_commit_cnt, perf_flush_cnt;
`endif

    reorder_buffer_param #(.ROB_WIDTH(RW), .XLEN(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .issue_type(issue_type), .issue_rd(issue_rd), .issue_pc(issue_pc),
        .issue_pred_pc(issue_pred_pc), .issue_done(issue_done), .issue_value(issue_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_next_pc(cdb_next_pc),
        .qry1_tag(qry1_tag), .qry2_tag(qry2_tag),
        .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
        .qry1_value(qry1_value), .qry2_value(qry2_value),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_store(commit_store),
        .flush_out(flush_out), .flush_pc(flush_pc)
`ifdef ROB_PERF_CNT_EN
        , .perf_commit_cnt(perf_commit_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [RW-1:0] tag;
        logic [4:0]    rd;
        logic [31:0]   value;
        logic          store;
        logic          flush;
        logic [31:0]   fpc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Commit monitor: every retire must match the next scoreboard entry.
    always @(negedge clk_in) begin
        if (!rst_in && commit_valid) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL commit_unexpected: tag=%0d rd=%0d value=%h, required no commit",
                         commit_tag, commit_rd, commit_value);
            end else begin
                e = sb.pop_front();
                if (commit_tag !== e.tag || commit_rd !== e.rd || commit_value !== e.value ||
                    commit_store !== e.store || flush_out !== e.flush ||
                    (e.flush && flush_pc !== e.fpc)) begin
                    n_fail++;
                    $display("FAIL commit_data: got tag=%0d rd=%0d val=%h st=%b fl=%b fpc=%h, required tag=%0d rd=%0d val=%h st=%b fl=%b fpc=%h",
                             commit_tag, commit_rd, commit_value, commit_store, flush_out, flush_pc,
                             e.tag, e.rd, e.value, e.store, e.flush, e.fpc);
                end
            end
        end
        if (!rst_in && flush_out) begin
            n_tests++;
            if (commit_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_alone: commit_valid=%b, required 1", commit_valid);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        rst_in = 1'b1; rdy_in = 1'b1; issue_valid = 1'b0; cdb_valid = 1'b0;
        repeat (2) cyc();
        rst_in = 1'b0;
        sb.delete();
    endtask

    task automatic do_issue(input logic [6:0] t, input logic [4:0] rd, input logic [31:0] pc,
                            input logic [31:0] pred, input logic dn, input logic [31:0] val);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pc = pc;
        issue_pred_pc = pred; issue_done = dn; issue_value = val;
        cyc();
        issue_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [RW-1:0] tag, input logic [31:0] val, input logic [31:0] npc);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val; cdb_next_pc = npc;
        cyc();
        cdb_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [RW-1:0] tag, input logic [4:0] rd, input logic [31:0] val,
                            input logic st, input logic fl, input logic [31:0] fpc);
        exp_t x;
        x.tag = tag; x.rd = rd; x.value = val; x.store = st; x.flush = fl; x.fpc = fpc;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({commit_valid, commit_store, flush_out} !== 3'b000 || commit_tag !== '0 ||
            commit_rd !== '0 || commit_value !== '0 || flush_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: cv=%b cs=%b fl=%b tag=%0d rd=%0d val=%h fpc=%h, required all 0",
                     commit_valid, commit_store, flush_out, commit_tag, commit_rd, commit_value, flush_pc);
        end
        n_tests++;
        if (issue_ready !== 1'b1 || issue_tag !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_issue: ready=%b tag=%0d, required ready=1 tag=0", issue_ready, issue_tag);
        end
        n_tests++;
        if (qry1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_qry: qry1_ready=%b, required 0", qry1_ready);
        end
        do_issue(7'd1, 5'd3, 32'h0, 32'h4, 1'b1, 32'hAB);
        cyc();
        n_tests++;
        if (commit_valid !== 1'b1 || commit_value !== 32'hAB) begin
            n_fail++;
            $display("FAIL reset_prelude_commit: cv=%b val=%h, required cv=1 val=000000ab", commit_valid, commit_value);
        end
        #1 rst_in = 1'b1;
        #1;
        n_tests++;
        if (commit_valid !== 1'b0 || commit_value !== 32'h0 || commit_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_async: cv=%b val=%h rd=%0d, required all 0", commit_valid, commit_value, commit_rd);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        push_exp(3'd0, 5'd5, 32'h11, 1'b0, 1'b0, 32'h0);
        do_issue(7'd19, 5'd5, 32'h0, 32'h4, 1'b0, 32'h0);
        do_cdb(3'd0, 32'h11, 32'h4);
        n_tests++;
        if (commit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: commit_valid=%b one cycle after issue, required 0", commit_valid);
        end
        cyc();
        n_tests++;
        if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_value !== 32'h11) begin
            n_fail++;
            $display("FAIL basic_latency: cv=%b rd=%0d val=%h, required cv=1 rd=5 val=00000011",
                     commit_valid, commit_rd, commit_value);
        end
        for (int i = 0; i < 40; i++) begin cyc(); if (sb.size() == 0) break; end
        n_tests++;
        if (sb.size() != 0 || issue_tag !== 3'd1 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_drain: outstanding=%0d tag=%0d ready=%b, required 0, 1, 1",
                     sb.size(), issue_tag, issue_ready);
        end
    endtask

    task automatic test_full_wrap();
        int ones;
        int bad_tag;
        apply_reset();
        bad_tag = 0;
        for (int i = 0; i < 8; i++) begin
            if (issue_tag !== 3'(i)) bad_tag++;
            push_exp(3'(i), 5'(i + 1), 32'h100 + i, 1'b0, 1'b0, 32'h0);
            do_issue(7'd19, 5'(i + 1), 32'(i * 4), 32'(i * 4 + 4), 1'b0, 32'h0);
        end
        n_tests++;
        if (bad_tag != 0 || issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_issue: tag errors=%0d ready=%b, required 0 errors ready=0", bad_tag, issue_ready);
        end
        for (int i = 7; i >= 0; i--) do_cdb(3'(i), 32'h100 + i, 32'(i * 4 + 4));
        issue_valid = 1'b1; issue_type = 7'd19; issue_rd = 5'd31; issue_done = 1'b1; issue_value = 32'hBAD;
        #1;
        n_tests++;
        if (issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_commit_cycle_ready: issue_ready=%b, required 0", issue_ready);
        end
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            issue_valid = 1'b0;
            if (commit_valid === 1'b1) ones++;
        end
        n_tests++;
        if (ones != 8) begin
            n_fail++;
            $display("FAIL full_back_to_back: commits in 8 cycles=%0d, required 8", ones);
        end
        for (int i = 0; i < 40; i++) begin cyc(); if (sb.size() == 0) break; end
        n_tests++;
        if (sb.size() != 0 || issue_tag !== 3'd0 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_wrap: outstanding=%0d tag=%0d ready=%b, required 0, 0, 1",
                     sb.size(), issue_tag, issue_ready);
        end
    endtask

    task automatic test_mispredict();
        apply_reset();
        push_exp(3'd0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h200);
        do_issue(7'd5, 5'd0, 32'h100, 32'h104, 1'b0, 32'h0);
        for (int i = 1; i <= 3; i++) do_issue(7'd19, 5'(i), 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), 1'b0, 32'h0);
        do_cdb(3'd1, 32'h1, 32'h10C);
        do_cdb(3'd0, 32'h0, 32'h200);
        issue_valid = 1'b1; issue_type = 7'd19; issue_rd = 5'd9; issue_done = 1'b1; issue_value = 32'h99;
        cyc();
        issue_valid = 1'b0;
        n_tests++;
        if (flush_out !== 1'b1 || flush_pc !== 32'h200 || issue_tag !== 3'd0 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mispredict_flush: fl=%b fpc=%h tag=%0d ready=%b, required 1 00000200 0 1",
                     flush_out, flush_pc, issue_tag, issue_ready);
        end
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_value = 32'hBAD; qry2_tag = 3'd2;
        #1;
        n_tests++;
        if (qry2_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mispredict_stale_cdb: qry2_ready=%b, required 0", qry2_ready);
        end
        cyc();
        cdb_valid = 1'b0;
        push_exp(3'd0, 5'd7, 32'h77, 1'b0, 1'b0, 32'h0);
        do_issue(7'd19, 5'd7, 32'h200, 32'h204, 1'b1, 32'h77);
        for (int i = 0; i < 40; i++) begin cyc(); if (sb.size() == 0) break; end
        n_tests++;
        if (sb.size() != 0 || issue_tag !== 3'd1) begin
            n_fail++;
            $display("FAIL mispredict_resume: outstanding=%0d tag=%0d, required 0 and 1", sb.size(), issue_tag);
        end
    endtask

    task automatic test_query();
        apply_reset();
        for (int i = 0; i < 3; i++) do_issue(7'd19, 5'(i + 1), 32'(4 * i), 32'(4 * i + 4), 1'b0, 32'h0);
        push_exp(3'd0, 5'd1, 32'hA0, 1'b0, 1'b0, 32'h0);
        push_exp(3'd1, 5'd2, 32'hA1, 1'b0, 1'b0, 32'h0);
        push_exp(3'd2, 5'd3, 32'hBEEF, 1'b0, 1'b0, 32'h0);
        qry1_tag = 3'd2; qry2_tag = 3'd0;
        #1;
        n_tests++;
        if (qry1_ready !== 1'b0 || qry2_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL query_pending: q1=%b q2=%b, required 0 0", qry1_ready, qry2_ready);
        end
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_value = 32'hDEAD; cdb_next_pc = 32'hC;
        #1;
        n_tests++;
        if (qry1_ready !== 1'b1 || qry1_value !== 32'hDEAD || qry2_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL query_cdb_bypass: q1=%b v1=%h q2=%b, required 1 0000dead 0",
                     qry1_ready, qry1_value, qry2_ready);
        end
        cyc();
        cdb_valid = 1'b0;
        #1;
        n_tests++;
        if (qry1_ready !== 1'b1 || qry1_value !== 32'hDEAD) begin
            n_fail++;
            $display("FAIL query_stored: q1=%b v1=%h, required 1 0000dead", qry1_ready, qry1_value);
        end
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_value = 32'hBEEF;
        #1;
        n_tests++;
        if (qry1_value !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL query_priority: v1=%h, required 0000beef", qry1_value);
        end
        cyc();
        cdb_valid = 1'b0;
        do_cdb(3'd0, 32'hA0, 32'h4);
        do_cdb(3'd1, 32'hA1, 32'h8);
        for (int i = 0; i < 40; i++) begin cyc(); if (sb.size() == 0) break; end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL query_drain: outstanding=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_store_freeze();
        int frozen_commits;
        apply_reset();
        push_exp(3'd0, 5'd0, 32'h55, 1'b1, 1'b0, 32'h0);
        do_issue(7'd18, 5'd12, 32'h40, 32'h44, 1'b0, 32'h0);
        do_cdb(3'd0, 32'h55, 32'h44);
        for (int i = 0; i < 40; i++) begin cyc(); if (sb.size() == 0) break; end
        for (int i = 1; i <= 3; i++) begin
            push_exp(3'(i), 5'(i), 32'hC0 + i, 1'b0, 1'b0, 32'h0);
            do_issue(7'd19, 5'(i), 32'h40 + 32'(4 * i), 32'h44 + 32'(4 * i), 1'b0, 32'h0);
        end
        for (int i = 1; i <= 3; i++) do_cdb(3'(i), 32'hC0 + i, 32'h0);
        rdy_in = 1'b0;
        issue_valid = 1'b1; issue_type = 7'd19; issue_rd = 5'd30; issue_done = 1'b1; issue_value = 32'hBAD;
        frozen_commits = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (commit_valid !== 1'b0) frozen_commits++;
        end
        issue_valid = 1'b0;
        n_tests++;
        if (frozen_commits != 0 || commit_tag !== 3'd2 || commit_value !== 32'hC2 || issue_tag !== 3'd4) begin
            n_fail++;
            $display("FAIL freeze_hold: commits=%0d tag=%0d val=%h itag=%0d, required 0 2 000000c2 4",
                     frozen_commits, commit_tag, commit_value, issue_tag);
        end
        rdy_in = 1'b1;
        cyc();
        n_tests++;
        if (commit_valid !== 1'b1 || commit_tag !== 3'd3) begin
            n_fail++;
            $display("FAIL freeze_resume: cv=%b tag=%0d, required 1 3", commit_valid, commit_tag);
        end
        for (int i = 0; i < 40; i++) begin cyc(); if (sb.size() == 0) break; end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL freeze_drain: outstanding=%0d, required 0", sb.size());
        end
    endtask

`ifdef ROB_PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            push_exp(3'(i), 5'(i + 1), 32'h300 + i, 1'b0, 1'b0, 32'h0);
            do_issue(7'd19, 5'(i + 1), 32'(4 * i), 32'(4 * i + 4), 1'b1, 32'h300 + i);
        end
        push_exp(3'd4, 5'd1, 32'h14, 1'b0, 1'b1, 32'h40);
        do_issue(7'd3, 5'd1, 32'h10, 32'h10, 1'b0, 32'h0);
        do_cdb(3'd4, 32'h14, 32'h40);
        for (int i = 0; i < 40; i++) begin cyc(); if (sb.size() == 0) break; end
        n_tests++;
        if (sb.size() != 0 || perf_commit_cnt !== 32'd5 || perf_flush_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL perf_counts: outstanding=%0d commits=%0d flushes=%0d, required 0 5 1",
                     sb.size(), perf_commit_cnt, perf_flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_mispredict();
        test_query();
        test_store_freeze();
`ifdef ROB_PERF_CNT_EN
        test_perf();
`endif
        repeat (3) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/reorder_buffer_param.md
Name: reorder_buffer_param

Overview:
Parametrised reorder buffer for the out-of-order RV32I core; successor to the fixed 8-entry RoB shell.
- Accepts in-order issue from the dispatcher and tags each entry with its index.
- Captures results from the CDB and forwards operand values to the dispatcher.
- Retires one instruction per cycle in program order to the register file and the LSB.
- Detects control-flow mispredicts at commit and broadcasts the machine-wide flush.

Parameters:
ROB_WIDTH, 3, log2 of entry count; legal range 2..5.
ROB_SIZE, 1<<ROB_WIDTH, entry count; derived, do not override.
XLEN, 32, data and PC width.

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  global enable; low = freeze
issue_valid  input  1  dispatcher presents an instruction
issue_ready  output  1  combinational; high when count < ROB_SIZE
issue_tag  output  ROB_WIDTH  tail index assigned to the issuing instruction
issue_type  input  7  decoded opcode code (lui=1 .. andr=37; beq..bgeu=5..10, jal=3, jalr=4, sb..sw=16..18)
issue_rd  input  5  destination register; 0 = none
issue_pc  input  XLEN  instruction PC
issue_pred_pc  input  XLEN  predicted next PC
issue_done  input  1  result already known at issue (lui/auipc)
issue_value  input  XLEN  result when issue_done=1
cdb_valid  input  1  CDB broadcast
cdb_tag  input  ROB_WIDTH  producing entry
cdb_value  input  XLEN  result (rd value; pc+4 for jal/jalr)
cdb_next_pc  input  XLEN  actual next PC; meaningful for types 3..10 only
qry1_tag, qry2_tag  input  ROB_WIDTH  operand lookups
qry1_ready, qry2_ready  output  1  entry done, or same-cycle CDB hit
qry1_value, qry2_value  output  XLEN  forwarded value
commit_valid  output  1  registered one-cycle retire pulse
commit_tag  output  ROB_WIDTH  retired entry
commit_rd  output  5  register to write
commit_value  output  XLEN  value to write
commit_store  output  1  retired entry is a store (types 16..18); LSB performs it
flush_out  output  1  registered one-cycle mispredict flush
flush_pc  output  XLEN  redirect PC

Behaviour:
- Storage: per entry {busy, done, type, rd, pc, pred_pc, value, next_pc}.
- Pointers: head, tail (ROB_WIDTH bits, wrap modulo ROB_SIZE) plus count (ROB_WIDTH+1 bits).
- Reset (async): head=tail=count=0, all busy=0.
  - Outputs reset to 0: commit_valid, commit_tag, commit_rd, commit_value, commit_store, flush_out, flush_pc.
- rdy_in=0:
  - No state changes.
  - Registered pulse outputs (commit_valid, commit_store, flush_out) are driven 0 the next cycle.
  - All other registered outputs hold.
- Issue: accepted when issue_valid && issue_ready && rdy_in.
  - Writes the entry at tail; busy=1; done=issue_done.
  - tail+1, count+1.
  - issue_tag always equals tail.
- CDB: on cdb_valid, if entry cdb_tag is busy, set done=1 and store value/next_pc. Otherwise ignore.
- Commit: when head entry is busy && done, retire it on that edge.
  - Outputs: commit_valid=1, commit_tag=head, commit_rd=rd (0 for branches and stores), commit_value=value, commit_store=(type in 16..18).
  - Then head+1, count-1.
- Mispredict: at commit of a type 3..10 entry whose next_pc != pred_pc:
  - flush_out=1 and flush_pc=next_pc, asserted together with that commit's commit_valid.
  - All busy cleared; head=tail=count=0.
  - Any issue or CDB in the same cycle is discarded.
  - The instruction after the flush is accepted the next cycle.
- Simultaneous issue and commit: count unchanged. issue_ready uses the pre-commit count, so a full buffer blocks issue even in a commit cycle.
- Same-cycle CDB on head: not committed until the next cycle.
- Minimum latency: issue at t, CDB at t+1, commit_valid visible after edge t+2.
- Query path is combinational. Priority: CDB match (cdb_valid && cdb_tag==qry_tag && busy) > stored done value > not ready.
- Wrap: pointers roll over ROB_SIZE-1 to 0 without bubbles. Full is count==ROB_SIZE; empty is count==0.

Optional Feature:
- Macro: ROB_PERF_CNT_EN.
- Defined: adds outputs perf_commit_cnt (32) and perf_flush_cnt (32).
  - Incremented on each commit and each flush respectively.
  - Reset to 0 asynchronously; held while rdy_in=0; wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then issue addi rd=5 (tag 0); CDB tag0 value 0x11 -> commit_valid=1, commit_rd=5, commit_value=0x11 two cycles after issue; count back to 0.
- Issue 8 entries, ROB_WIDTH=3 -> issue_ready=0 after the 8th. Complete out of order (tags 7..0) -> commits in order 0..7, one per cycle; tail wraps to 0.
- beq at pc 0x100, pred_pc 0x104; CDB next_pc 0x200; 3 younger entries issued -> flush_out=1, flush_pc=0x200, count=0. Younger entries never commit; a CDB to a flushed tag is ignored.
- qry1_tag=2 in the same cycle as CDB tag2 value 0xDEAD -> qry1_ready=1, qry1_value=0xDEAD combinationally.
- sw issued with issue_done=0, then CDB -> commit_store=1, commit_rd=0. rdy_in low for 3 cycles mid-stream -> no commits, state unchanged, resumes identically.
- ROB_PERF_CNT_EN defined, 5 commits incl. 1 mispredict -> perf_commit_cnt=5, perf_flush_cnt=1.
